// File: rtl/pac_bank_mapper.sv
// Banked MSX cartridge ROM mapper with a key-unlocked SRAM overlay on window 0.
// Optional register/key readback is enabled by defining PAC_BANK_MAPPER_READBACK_EN.
module pac_bank_mapper #(
  parameter int          NUM_WINDOWS   = 4,
  parameter int          WINDOW_BITS   = 13,
  parameter int          BANK_BITS     = 8,
  parameter logic [23:0] RAM_ADDR_ROM  = 24'h000000,
  parameter logic [23:0] RAM_ADDR_SRAM = 24'h100000,
  parameter logic [15:0] REG_BASE      = 16'h7FF0,
  parameter logic [15:0] KEY_ADDR      = 16'h5FFE,
  parameter logic [15:0] KEY_VALUE     = 16'h694D
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BUS_RESET_n,
  input  logic [15:0] BUS_ADDR,
  input  logic [7:0]  BUS_DIN,
  input  logic        BUS_SLTSL_n,
  input  logic        BUS_MERQ_n,
  input  logic        BUS_RD_n,
  input  logic        BUS_WR_n,
  output logic [7:0]  BUS_DOUT,
  output logic        BUS_BUSDIR_n,
  output logic [23:0] RAM_ADDR,
  output logic [7:0]  RAM_DIN,
  output logic        RAM_WE_n,
  output logic        RAM_OE_n,
  input  logic [7:0]  RAM_DOUT,
  output logic        SRAM_ACTIVE
);

  localparam logic [16:0] HIT_END = 17'(32'h4000 + (NUM_WINDOWS << WINDOW_BITS));

  logic [NUM_WINDOWS-1:0][BANK_BITS-1:0] bank_q, bank_d;
  logic [1:0][7:0] key_q, key_d;
  logic        prev_wr_n_q, prev_wr_n_d;
  logic [23:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_din_q, ram_din_d, bus_dout_q, bus_dout_d;
  logic        ram_we_n_q, ram_we_n_d, ram_oe_n_q, ram_oe_n_d;
  logic        busdir_n_q, busdir_n_d, sram_active_q, sram_active_d;

  logic        wr, rd, hit, det_wr, sram_en, sram_win;
  logic [15:0] off;
  logic [1:0]  w_idx;
  logic [BANK_BITS-1:0] bank_sel;
  logic [23:0] rom_addr, sram_addr;

  assign wr      = !BUS_SLTSL_n && !BUS_MERQ_n && !BUS_WR_n;
  assign rd      = !BUS_SLTSL_n && !BUS_MERQ_n && !BUS_RD_n;
  assign det_wr  = prev_wr_n_q && wr;
  assign off     = BUS_ADDR - 16'h4000;
  assign hit     = (BUS_ADDR >= 16'h4000) && ({1'b0, BUS_ADDR} < HIT_END);
  assign w_idx   = 2'(off >> WINDOW_BITS);
  assign sram_en = (key_q == KEY_VALUE);
  assign sram_win = hit && (w_idx == 2'd0) && sram_en;

  always_comb begin
    bank_sel = '0;
    for (int i = 0; i < NUM_WINDOWS; i++)
      if (w_idx == 2'(i)) bank_sel = bank_q[i];
  end

  assign rom_addr  = RAM_ADDR_ROM + 24'({bank_sel, BUS_ADDR[WINDOW_BITS-1:0]});
  assign sram_addr = RAM_ADDR_SRAM + 24'(BUS_ADDR[WINDOW_BITS-1:0]);

  always_comb begin
    bank_d        = bank_q;
    key_d         = key_q;
    prev_wr_n_d   = !wr;
    ram_addr_d    = '0;
    ram_din_d     = '0;
    ram_we_n_d    = 1'b1;
    ram_oe_n_d    = 1'b1;
    bus_dout_d    = '0;
    busdir_n_d    = 1'b1;
    sram_active_d = sram_en;

    // Register writes latch even when the same write also lands in SRAM.
    if (det_wr) begin
      for (int i = 0; i < NUM_WINDOWS; i++)
        if (BUS_ADDR == 16'(REG_BASE + i)) bank_d[i] = BUS_DIN[BANK_BITS-1:0];
      if (BUS_ADDR[15:1] == KEY_ADDR[15:1]) key_d[BUS_ADDR[0]] = BUS_DIN;
    end

    if (wr) begin
      // Uses the key as it stood before this write, so a key-breaking write still hits SRAM.
      if (sram_win) begin
        ram_addr_d = sram_addr;
        ram_din_d  = BUS_DIN;
        ram_we_n_d = 1'b0;
      end
    end else if (rd) begin
      if (hit) begin
        ram_addr_d = sram_win ? sram_addr : rom_addr;
        ram_oe_n_d = 1'b0;
        busdir_n_d = 1'b0;
        bus_dout_d = RAM_DOUT;
      end
`ifdef PAC_BANK_MAPPER_READBACK_EN
      for (int i = 0; i < NUM_WINDOWS; i++)
        if (BUS_ADDR == 16'(REG_BASE + i)) begin
          ram_addr_d = '0;
          ram_oe_n_d = 1'b1;
          busdir_n_d = 1'b0;
          bus_dout_d = 8'(bank_q[i]);
        end
      if (!sram_en && BUS_ADDR[15:1] == KEY_ADDR[15:1]) begin
        ram_addr_d = '0;
        ram_oe_n_d = 1'b1;
        busdir_n_d = 1'b0;
        bus_dout_d = key_q[BUS_ADDR[0]];
      end
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || !BUS_RESET_n) begin
      for (int i = 0; i < NUM_WINDOWS; i++) bank_q[i] <= BANK_BITS'(i);
      key_q         <= '0;
      // Idle when the bus is quiet; a strobe held across reset must toggle before it counts.
      prev_wr_n_q   <= !wr;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      ram_we_n_q    <= 1'b1;
      ram_oe_n_q    <= 1'b1;
      bus_dout_q    <= '0;
      busdir_n_q    <= 1'b1;
      sram_active_q <= 1'b0;
    end else begin
      bank_q        <= bank_d;
      key_q         <= key_d;
      prev_wr_n_q   <= prev_wr_n_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      ram_we_n_q    <= ram_we_n_d;
      ram_oe_n_q    <= ram_oe_n_d;
      bus_dout_q    <= bus_dout_d;
      busdir_n_q    <= busdir_n_d;
      sram_active_q <= sram_active_d;
    end
  end

  assign RAM_ADDR     = ram_addr_q;
  assign RAM_DIN      = ram_din_q;
  assign RAM_WE_n     = ram_we_n_q;
  assign RAM_OE_n     = ram_oe_n_q;
  assign BUS_DOUT     = bus_dout_q;
  assign BUS_BUSDIR_n = busdir_n_q;
  assign SRAM_ACTIVE  = sram_active_q;

endmodule
